cpu_ctrl: RTL and testbench
===========================

// Module: cpu_ctrl
// PURPOSE
//  Multi-cycle fetch/decode/execute controller for the 8-bit model machine; initiator side of the
//  register-file interface (drives raa/rwba/we/i, consumes s/d). Fetches from async instruction ROM,
//  sequences ALU ops, data-memory load/store, jumps and HALT. Sits between ROM, ALU, data RAM and reg_group.
// PARAMETERS
//  DW   8  datapath / instruction / immediate width
//  AW   8  PC and data-memory address width
//  RW   2  register address width (A=00, B=01, C=10; 11 illegal)
// PORTS
//  clk        in   1   clock; all controller state on posedge
//  rst_n      in   1   synchronous active-low reset
//  rom_addr   out  AW  instruction address (= pc)
//  rom_data   in   DW  async ROM data for rom_addr
//  raa        out  RW  reg-file source select (rs)
//  rwba       out  RW  reg-file dest/write select (rd)
//  we         out  1   reg-file write enable, active low; reg file captures on negedge clk
//  i          out  DW  reg-file write data
//  s_in       in   DW  reg-file source read data (reg[raa])
//  alu_op     out  3   0 PASS_S,1 ADD,2 SUB,3 AND,4 OR,5 NOT_S; operands a=d, b=s
//  alu_y      in   DW  ALU result
//  alu_c      in   1   ALU carry/borrow
//  alu_z      in   1   ALU zero
//  mem_addr   out  AW  data-memory address
//  mem_wdata  out  DW  data-memory write data
//  mem_rd_n   out  1   data-memory read strobe, active low
//  mem_wr_n   out  1   data-memory write strobe, active low
//  mem_rdata  in   DW  data-memory async read data
//  halted     out  1   high in HALT state
//  err        out  1   one-cycle pulse: illegal opcode or register field 11
// BEHAVIOUR
//  Instr byte: [7:4] op, [3:2] rs, [1:0] rd. Ops: 0 NOP,1 MOV rd<=rs,2 ADD rd<=rd+rs,3 SUB rd<=rd-rs,
//   4 AND,5 OR,6 NOT rd<=~rs,7 LDI rd<=imm,8 LD rd<=M[imm],9 ST M[imm]<=rs,A JMP,B JZ,C JC,F HALT.
//   Ops 7,8,9,A,B,C are two-byte (imm follows). Ops D,E: NOP + err pulse.
//  FSM: FETCH -> DECODE -> [IMM] -> EXEC -> [WB] -> FETCH; HALT absorbing until reset.
//   FETCH: ir<=rom_data, pc<=pc+1.  DECODE: two-byte -> IMM, HALT -> HALT, NOP/illegal -> FETCH, else EXEC.
//   IMM: imm<=rom_data, pc<=pc+1.
//   EXEC: raa=rs, rwba=rd, alu_op set; ALU ops: wbd<=alu_y, Z<=alu_z, C<=alu_c -> WB.
//    MOV/LDI: wbd<=s_in / imm, flags unchanged -> WB. LD: mem_addr=imm, mem_rd_n=0, wbd<=mem_rdata -> WB.
//    ST: mem_addr=imm, mem_wdata=s_in, mem_wr_n=0 this cycle only -> FETCH.
//    JMP: pc<=imm. JZ/JC: pc<=imm iff Z/C==1 (flag value before this instr) -> FETCH.
//   WB: we=0 for exactly this cycle, i=wbd, rwba=rd held stable whole cycle -> FETCH.
//  Latency: reg op 4 cycles; LDI/LD 5; ST/JMP/JZ/JC 4; NOP 2.
//  Reset values: pc=0, rom_addr=0, raa=0, rwba=0, we=1, i=0, alu_op=0, mem_addr=0, mem_wdata=0,
//   mem_rd_n=1, mem_wr_n=1, halted=0, err=0, Z=C=0, ir=imm=wbd=0, state FETCH.
//  Boundaries: pc wraps FF->00 (incl. imm fetch at FF); rs or rd==11 on a reg-using op -> err pulse in
//   DECODE, no write, -> FETCH (imm still consumed if two-byte). Writes to rd only in WB; we never low
//   outside WB. rst_n low during WB: that cycle's negedge write completes (reg file unreset); we=1
//   from the reset edge. Only ALU ops 2-6 update flags.
// STRUCTURE
//  Package cpu_pkg: opcode localparams, alu_op codes, FSM state encodings, register codes.
//  Sub-module cpu_decode: combinational ir -> {two_byte, uses_rs, uses_rd, is_alu, alu_op, illegal}.
// TESTING
//  reset, ROM {71 05,F0}: LDI B,5 -> one we=0 cycle, rwba=01, i=05 at cycle 5; halted=1 after.
//  A=3,B=5, ROM {21}: ADD B<=B+A -> raa=00, rwba=01, alu_op=1, i=alu_y=08, Z=0, we low 1 cycle.
//  ROM {30}, A=1: SUB A-A -> alu_z=1; next {B0 20}: JZ 20 -> rom_addr=20 next FETCH; with Z=0 -> 02.
//  ROM {94 40}: ST M[40]<=B -> mem_wr_n=0 one cycle, mem_addr=40, mem_wdata=s_in; we stays 1.
//  ROM at FF = 71, 00 = AA: LDI imm fetched from 00, pc=01 after; ROM {13}/{D0}: err=1 one cycle, no write.
//  rst_n=0 during WB and during HALT -> next cycle all outputs at reset values, state FETCH, pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, register codes and FSM states for the model CPU controller
package cpu_pkg;

    localparam int CPU_DW = 8;
    localparam int CPU_AW = 8;
    localparam int CPU_RW = 2;

    // Opcode field ir[7:4]; 0xD and 0xE are unassigned and decode as illegal.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU function select; operand a is reg[rwba], operand b is reg[raa].
    localparam logic [2:0] ALU_PASS_S = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_NOT_S  = 3'd5;

    // Register file addresses; 11 selects no register and is rejected.
    localparam logic [1:0] REG_A   = 2'b00;
    localparam logic [1:0] REG_B   = 2'b01;
    localparam logic [1:0] REG_C   = 2'b10;
    localparam logic [1:0] REG_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IMM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational instruction classifier for the model CPU controller
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic       two_byte,
    output logic       uses_rs,
    output logic       uses_rd,
    output logic       is_alu,
    output logic [2:0] alu_op,
    output logic       illegal
);

    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] rd;
    logic       bad_op;

    assign op = ir[7:4];
    assign rs = ir[3:2];
    assign rd = ir[1:0];

    // Classify the opcode, then flag unassigned opcodes or a used register field of 11
    always_comb begin
        two_byte = 1'b0;
        uses_rs  = 1'b0;
        uses_rd  = 1'b0;
        is_alu   = 1'b0;
        alu_op   = ALU_PASS_S;
        bad_op   = 1'b0;
        case (op)
            OP_NOP, OP_HALT: ;
            OP_MOV: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
            end
            OP_ADD: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_alu  = 1'b1;
                alu_op  = ALU_ADD;
            end
            OP_SUB: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_alu  = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_AND: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_alu  = 1'b1;
                alu_op  = ALU_AND;
            end
            OP_OR: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_alu  = 1'b1;
                alu_op  = ALU_OR;
            end
            OP_NOT: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_alu  = 1'b1;
                alu_op  = ALU_NOT_S;
            end
            OP_LDI, OP_LD: begin
                two_byte = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_ST: begin
                two_byte = 1'b1;
                uses_rs  = 1'b1;
            end
            OP_JMP, OP_JZ, OP_JC: begin
                two_byte = 1'b1;
            end
            default: bad_op = 1'b1;
        endcase
        illegal = bad_op
                | (uses_rs && (rs == REG_BAD))
                | (uses_rd && (rd == REG_BAD));
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle fetch/decode/execute controller for the 8-bit model machine
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int AW = CPU_AW,
    parameter int RW = CPU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [RW-1:0] raa,
    output logic [RW-1:0] rwba,
    output logic          we,
    output logic [DW-1:0] i,
    input  logic [DW-1:0] s_in,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_c,
    input  logic          alu_z,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd_n,
    output logic          mem_wr_n,
    input  logic [DW-1:0] mem_rdata,
    output logic          halted,
    output logic          err
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] imm;
    logic [DW-1:0] wbd;
    logic          z_flag;
    logic          c_flag;
    logic          skip;

    logic [3:0]    op;
    logic [RW-1:0] rs;
    logic [RW-1:0] rd;

    logic          dec_two_byte;
    logic          dec_uses_rs;
    logic          dec_uses_rd;
    logic          dec_is_alu;
    logic [2:0]    dec_alu_op;
    logic          dec_illegal;

    assign op = ir[7:4];
    assign rs = ir[3:2];
    assign rd = ir[1:0];

    cpu_decode u_decode (
        .ir       (ir),
        .two_byte (dec_two_byte),
        .uses_rs  (dec_uses_rs),
        .uses_rd  (dec_uses_rd),
        .is_alu   (dec_is_alu),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal)
    );

    // State register; reset always returns to FETCH, including out of HALT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all interface outputs, decoded from the current state only
    always_comb begin
        state_nxt = state;
        rom_addr  = pc;
        raa       = '0;
        rwba      = '0;
        we        = 1'b1;
        i         = '0;
        alu_op    = ALU_PASS_S;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_n  = 1'b1;
        mem_wr_n  = 1'b1;
        halted    = 1'b0;
        err       = 1'b0;
        case (state)
            ST_FETCH: state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (dec_illegal) begin
                    // Rejected instruction still consumes its immediate byte
                    err       = 1'b1;
                    state_nxt = dec_two_byte ? ST_IMM : ST_FETCH;
                end else if (op == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else if (dec_two_byte) begin
                    state_nxt = ST_IMM;
                end else if (op == OP_NOP) begin
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_IMM: state_nxt = skip ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                raa    = dec_uses_rs ? rs : REG_A;
                rwba   = dec_uses_rd ? rd : REG_A;
                alu_op = dec_alu_op;
                if (op == OP_LD) begin
                    mem_addr = imm;
                    mem_rd_n = 1'b0;
                end
                if (op == OP_ST) begin
                    mem_addr  = imm;
                    mem_wdata = s_in;
                    mem_wr_n  = 1'b0;
                end
                case (op)
                    OP_ST, OP_JMP, OP_JZ, OP_JC: state_nxt = ST_FETCH;
                    default:                     state_nxt = ST_WB;
                endcase
            end
            ST_WB: begin
                // Register file captures on the falling edge inside this cycle
                rwba      = rd;
                we        = 1'b0;
                i         = wbd;
                state_nxt = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // Datapath registers: pc, instruction, immediate, write-back data and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            imm    <= '0;
            wbd    <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            skip   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir <= rom_data;
                    pc <= pc + 1'b1;
                end
                ST_DECODE: skip <= dec_illegal;
                ST_IMM: begin
                    imm <= rom_data;
                    pc  <= pc + 1'b1;
                end
                ST_EXEC: begin
                    if (dec_is_alu) begin
                        wbd    <= alu_y;
                        z_flag <= alu_z;
                        c_flag <= alu_c;
                    end
                    // Conditional jumps test the flags left by the previous instruction
                    case (op)
                        OP_MOV: wbd <= s_in;
                        OP_LDI: wbd <= imm;
                        OP_LD:  wbd <= mem_rdata;
                        OP_JMP: pc  <= imm;
                        OP_JZ:  if (z_flag) pc <= imm;
                        OP_JC:  if (c_flag) pc <= imm;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - directed scoreboard bench for cpu_ctrl with ROM, ALU, register file and RAM models
module tb_cpu_ctrl;
    import cpu_pkg::*;

    typedef struct packed {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [1:0] raa;
    logic [1:0] rwba;
    logic       we;
    logic [7:0] i;
    logic [7:0] s_in;
    logic [2:0] alu_op;
    logic [7:0] alu_y;
    logic       alu_c;
    logic       alu_z;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rd_n;
    logic       mem_wr_n;
    logic [7:0] mem_rdata;
    logic       halted;
    logic       err;

    logic [7:0] rom  [256];
    logic [7:0] regs [4];
    logic [7:0] dmem [256];
    logic [8:0] alu_r;

    int  cyc = 0;
    ev_t wq_obs[$];
    ev_t sq_obs[$];
    ev_t eq_obs[$];
    ev_t wq_exp[$];
    ev_t sq_exp[$];
    ev_t eq_exp[$];
    int  w_rd = 0;
    int  s_rd = 0;
    int  e_rd = 0;
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    cpu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .raa       (raa),
        .rwba      (rwba),
        .we        (we),
        .i         (i),
        .s_in      (s_in),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd_n  (mem_rd_n),
        .mem_wr_n  (mem_wr_n),
        .mem_rdata (mem_rdata),
        .halted    (halted),
        .err       (err)
    );

    assign rom_data  = rom[rom_addr];
    assign s_in      = regs[raa];
    assign mem_rdata = dmem[mem_addr];

    // ALU model: a = reg[rwba], b = reg[raa]
    always_comb begin
        alu_r = '0;
        case (alu_op)
            3'd0:    alu_r = {1'b0, s_in};
            3'd1:    alu_r = {1'b0, regs[rwba]} + {1'b0, s_in};
            3'd2:    alu_r = {1'b0, regs[rwba]} - {1'b0, s_in};
            3'd3:    alu_r = {1'b0, regs[rwba] & s_in};
            3'd4:    alu_r = {1'b0, regs[rwba] | s_in};
            3'd5:    alu_r = {1'b0, ~s_in};
            default: alu_r = '0;
        endcase
    end
    assign alu_y = alu_r[7:0];
    assign alu_c = alu_r[8];
    assign alu_z = (alu_r[7:0] == 8'h00);

    // Cycle number since reset release; the first FETCH cycle is 1
    always @(posedge clk) cyc <= (!rst_n) ? 1 : cyc + 1;

    // Register file / data RAM models and event capture on the falling edge
    always @(negedge clk) begin
        if (we === 1'b0) begin
            regs[rwba] <= i;
            wq_obs.push_back(ev_t'{cyc, {6'b0, rwba}, i});
        end
        if (mem_wr_n === 1'b0) begin
            dmem[mem_addr] <= mem_wdata;
            sq_obs.push_back(ev_t'{cyc, mem_addr, mem_wdata});
        end
        if (err === 1'b1) begin
            eq_obs.push_back(ev_t'{cyc, 8'h00, 8'h00});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("cycle_reach", 64'(cyc), 64'(n));
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input logic [127:0] prog, input int n);
        for (int k = 0; k < 256; k++) rom[k] = 8'h00;
        for (int k = 0; k < n; k++) rom[k] = prog[8*(n-1-k) +: 8];
    endtask

    task automatic ew(input int c, input logic [7:0] a, input logic [7:0] d);
        wq_exp.push_back(ev_t'{c, a, d});
    endtask

    task automatic es(input int c, input logic [7:0] a, input logic [7:0] d);
        sq_exp.push_back(ev_t'{c, a, d});
    endtask

    task automatic ee(input int c);
        eq_exp.push_back(ev_t'{c, 8'h00, 8'h00});
    endtask

    task automatic score_one(input string tag, input ev_t exp_q[$], input ev_t obs_q[$], inout int rd);
        foreach (exp_q[k]) begin
            if (rd < obs_q.size()) begin
                chk(tag, 64'(obs_q[rd]), 64'(exp_q[k]));
                rd++;
            end else begin
                chk({tag, "_missing"}, 64'h0, 64'(exp_q[k]));
            end
        end
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(rd));
        rd = obs_q.size();
    endtask

    task automatic score();
        score_one("reg_write", wq_exp, wq_obs, w_rd);
        score_one("mem_store", sq_exp, sq_obs, s_rd);
        score_one("err_pulse", eq_exp, eq_obs, e_rd);
        wq_exp.delete();
        sq_exp.delete();
        eq_exp.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        load(128'h0, 0);
        hold_reset();
        chk("rst_rom_addr", rom_addr, 8'h00);
        chk("rst_raa", raa, 2'b00);
        chk("rst_rwba", rwba, 2'b00);
        chk("rst_we", we, 1'b1);
        chk("rst_i", i, 8'h00);
        chk("rst_alu_op", alu_op, 3'd0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_mem_rd_n", mem_rd_n, 1'b1);
        chk("rst_mem_wr_n", mem_wr_n, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", err, 1'b0);

        // LDI B,5 ; HALT
        load(128'h7105F0, 3);
        ew(5, 8'h01, 8'h05);
        rst_n = 1'b1;
        go(4);
        chk("ldi_exec_we", we, 1'b1);
        go(5);
        chk("ldi_wb_we", we, 1'b0);
        chk("ldi_wb_rwba", rwba, 2'b01);
        chk("ldi_wb_i", i, 8'h05);
        go(6);
        chk("ldi_after_we", we, 1'b1);
        go(8);
        chk("halt_halted", halted, 1'b1);
        go(12);
        chk("halt_stays", halted, 1'b1);
        chk("halt_pc", rom_addr, 8'h03);
        score();

        // LDI A,3 ; LDI B,5 ; ADD B<=B+A ; HALT
        hold_reset();
        load(128'h7003710521F0, 6);
        ew(5, 8'h00, 8'h03);
        ew(10, 8'h01, 8'h05);
        ew(14, 8'h01, 8'h08);
        rst_n = 1'b1;
        go(13);
        chk("add_raa", raa, 2'b00);
        chk("add_rwba", rwba, 2'b01);
        chk("add_alu_op", alu_op, 3'd1);
        chk("add_we_exec", we, 1'b1);
        go(14);
        chk("add_wb_i", i, 8'h08);
        go(20);
        chk("add_halted", halted, 1'b1);
        score();

        // LDI A,1 ; SUB A<=A-A ; JZ 20 (taken)
        hold_reset();
        load(128'h700130B020, 5);
        rom[8'h20] = 8'hF0;
        ew(5, 8'h00, 8'h01);
        ew(9, 8'h00, 8'h00);
        rst_n = 1'b1;
        go(8);
        chk("sub_alu_op", alu_op, 3'd2);
        go(14);
        chk("jz_taken_addr", rom_addr, 8'h20);
        go(18);
        chk("jz_taken_halt", halted, 1'b1);
        score();

        // LDI A,1 ; ADD A<=A+A ; JZ 20 (not taken) ; HALT
        hold_reset();
        load(128'h700120B020F0, 6);
        ew(5, 8'h00, 8'h01);
        ew(9, 8'h00, 8'h02);
        rst_n = 1'b1;
        go(14);
        chk("jz_fall_addr", rom_addr, 8'h05);
        score();

        // LDI A,FF ; LDI B,1 ; ADD B<=B+A (carry) ; JC 30 (taken)
        hold_reset();
        load(128'h70FF710121C030F0, 8);
        rom[8'h30] = 8'hF0;
        ew(5, 8'h00, 8'hFF);
        ew(10, 8'h01, 8'h01);
        ew(14, 8'h01, 8'h00);
        rst_n = 1'b1;
        go(19);
        chk("jc_taken_addr", rom_addr, 8'h30);
        score();

        // LDI B,5A ; ST M[40]<=B ; LD C<=M[40] ; MOV A<=C ; NOT B<=~C ; HALT
        hold_reset();
        load(128'h715A944082401869F0, 9);
        ew(5, 8'h01, 8'h5A);
        es(9, 8'h40, 8'h5A);
        ew(14, 8'h02, 8'h5A);
        ew(18, 8'h00, 8'h5A);
        ew(22, 8'h01, 8'hA5);
        rst_n = 1'b1;
        go(9);
        chk("st_wr_n", mem_wr_n, 1'b0);
        chk("st_addr", mem_addr, 8'h40);
        chk("st_wdata", mem_wdata, 8'h5A);
        chk("st_we", we, 1'b1);
        go(10);
        chk("st_wr_n_release", mem_wr_n, 1'b1);
        go(13);
        chk("ld_rd_n", mem_rd_n, 1'b0);
        chk("ld_addr", mem_addr, 8'h40);
        go(26);
        chk("mem_halted", halted, 1'b1);
        score();

        // JMP FF ; LDI B at FF takes its immediate from address 00
        hold_reset();
        load(128'hAAFF, 2);
        rom[8'hFF] = 8'h71;
        ew(9, 8'h01, 8'hAA);
        rst_n = 1'b1;
        go(5);
        chk("wrap_fetch_ff", rom_addr, 8'hFF);
        go(7);
        chk("wrap_imm_00", rom_addr, 8'h00);
        go(10);
        chk("wrap_next_01", rom_addr, 8'h01);
        go(13);
        chk("wrap_halted", halted, 1'b1);
        score();

        // LDI D(11),55 ; MOV D<=A ; opcode D ; HALT  -> three err pulses, no writes
        hold_reset();
        load(128'h735513D0F0, 5);
        ee(2);
        ee(5);
        ee(7);
        rst_n = 1'b1;
        go(2);
        chk("err_first", err, 1'b1);
        go(3);
        chk("err_clears", err, 1'b0);
        go(4);
        chk("err_imm_consumed", rom_addr, 8'h02);
        go(11);
        chk("err_halted", halted, 1'b1);
        score();

        // Reset asserted during WB: write still lands, outputs return to reset values
        hold_reset();
        load(128'h7105F0, 3);
        ew(5, 8'h01, 8'h05);
        rst_n = 1'b1;
        go(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwb_we", we, 1'b1);
        chk("rstwb_rwba", rwba, 2'b00);
        chk("rstwb_i", i, 8'h00);
        chk("rstwb_rom_addr", rom_addr, 8'h00);
        score();

        // Reset asserted during HALT
        load(128'hF0, 1);
        rst_n = 1'b1;
        go(4);
        chk("rsthalt_before", halted, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsthalt_halted", halted, 1'b0);
        chk("rsthalt_rom_addr", rom_addr, 8'h00);
        chk("rsthalt_err", err, 1'b0);
        score();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
